// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pipe_pkg - shared types/constants for pipeline_hazard_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
package riscv_pipe_pkg;

  localparam int unsigned SB_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             reg_wr;
    logic             mem_rd;
  } sb_entry_t;

  // x0 is hardwired, so an entry writing it can never be a producer.
  function automatic logic sb_is_src(input sb_entry_t e);
    return e.valid && e.reg_wr && (e.rd != '0);
  endfunction

  function automatic logic [1:0] fwd_select(input logic used, input logic ex_hit,
                                            input logic ex_load, input logic mem_hit);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (used) begin
      if (ex_hit)       sel = ex_load ? FWD_REGFILE : FWD_EXMEM;
      else if (mem_hit) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_scoreboard - EX/MEM/WB destination shift register + rs matching. Rev 1.0
// ----------------------------------------------------------------------------
module hazard_scoreboard
  import riscv_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic             ex_kill_i,
  input  sb_entry_t        id_entry_i,
  input  logic [SB_AW-1:0] rs1_i,
  input  logic [SB_AW-1:0] rs2_i,
  output logic [2:0]       rs1_hit_o,
  output logic [2:0]       rs2_hit_o,
  output logic             ex_load_o
);

  // Index 0 = EX, 1 = MEM, 2 = WB.
  sb_entry_t [2:0] stage_q;
  logic            unused_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (shift_en_i) begin
      stage_q[2] <= stage_q[1];
      stage_q[1] <= stage_q[0];
      stage_q[0] <= ex_kill_i ? sb_entry_t'('0) : id_entry_i;
    end
  end

  for (genvar s = 0; s < 3; s++) begin : g_match
    assign rs1_hit_o[s] = sb_is_src(stage_q[s]) && (stage_q[s].rd == rs1_i);
    assign rs2_hit_o[s] = sb_is_src(stage_q[s]) && (stage_q[s].rd == rs2_i);
  end

  assign ex_load_o = stage_q[0].mem_rd;
  assign unused_ok = ^{stage_q[1].mem_rd, stage_q[2].mem_rd};

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl - stall/flush/freeze/forwarding control for a 5-stage
// RISC-V pipeline. Optional perf counters: HAZARD_PERF_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_wr_i,
  input  logic              id_mem_rd_i,
  input  logic              ex_redirect_i,
  input  logic              mem_busy_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              bubble_ex_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              freeze_o,
  output logic [FWD_W-1:0]  fwd_rs1_sel_o,
  output logic [FWD_W-1:0]  fwd_rs2_sel_o,
  output logic              id_wb_bypass_rs1_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
  output logic [31:0]       freeze_cnt_o,
`endif
  output logic              id_wb_bypass_rs2_o
);

  hz_state_e        state_q;
  sb_entry_t        id_entry;
  logic [2:0]       rs1_hit;
  logic [2:0]       rs2_hit;
  logic             ex_load;
  logic             load_use;
  logic             freeze;
  logic             flush;
  logic             lu_stall;
  logic [FWD_W-1:0] fwd_rs1_q;
  logic [FWD_W-1:0] fwd_rs2_q;
  logic [FWD_W-1:0] fwd_rs1_d;
  logic [FWD_W-1:0] fwd_rs2_d;

  assign id_entry.valid  = id_valid_i;
  assign id_entry.rd     = SB_AW'(id_rd_i);
  assign id_entry.reg_wr = id_reg_wr_i;
  assign id_entry.mem_rd = id_mem_rd_i;

  hazard_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (~freeze),
    .ex_kill_i  (lu_stall | flush | ~id_valid_i),
    .id_entry_i (id_entry),
    .rs1_i      (SB_AW'(id_rs1_i)),
    .rs2_i      (SB_AW'(id_rs2_i)),
    .rs1_hit_o  (rs1_hit),
    .rs2_hit_o  (rs2_hit),
    .ex_load_o  (ex_load)
  );

  // Gating with rst_n keeps every control output low while reset is held,
  // even if mem_busy/ex_redirect are still asserted by the datapath.
  assign freeze   = rst_n & mem_busy_i;
  assign flush    = rst_n & ~mem_busy_i & ex_redirect_i & (state_q != ST_FLUSH);
  assign load_use = rst_n & id_valid_i & ex_load &
                    ((id_rs1_used_i & rs1_hit[0]) | (id_rs2_used_i & rs2_hit[0]));
  assign lu_stall = load_use & ~freeze & ~flush;

  assign stall_if_o         = freeze | lu_stall;
  assign stall_id_o         = freeze | lu_stall;
  assign bubble_ex_o        = lu_stall;
  assign flush_ifid_o       = flush;
  assign flush_idex_o       = flush;
  assign freeze_o           = freeze;
  assign id_wb_bypass_rs1_o = rs1_hit[2];
  assign id_wb_bypass_rs2_o = rs2_hit[2];

  // A redirect seen while already in FLUSH is the stale one just serviced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      unique case (state_q)
        ST_FREEZE: if (!mem_busy_i) state_q <= flush ? ST_FLUSH : ST_RUN;
        ST_FLUSH:  state_q <= mem_busy_i ? ST_FREEZE : ST_RUN;
        default: begin
          if (mem_busy_i) state_q <= ST_FREEZE;
          else if (flush) state_q <= ST_FLUSH;
          else            state_q <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    fwd_rs1_d = FWD_W'(fwd_select(id_rs1_used_i, rs1_hit[0], ex_load, rs1_hit[1]));
    fwd_rs2_d = FWD_W'(fwd_select(id_rs2_used_i, rs2_hit[0], ex_load, rs2_hit[1]));
    if (lu_stall || flush || !id_valid_i) begin
      fwd_rs1_d = FWD_W'(FWD_REGFILE);
      fwd_rs2_d = FWD_W'(FWD_REGFILE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_rs1_q <= '0;
      fwd_rs2_q <= '0;
    end else if (!freeze) begin
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  assign fwd_rs1_sel_o = fwd_rs1_q;
  assign fwd_rs2_sel_o = fwd_rs2_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] freeze_cnt_q;

  // stall_cnt counts load-use stalls only; freeze cycles have their own counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (lu_stall && (stall_cnt_q != '1))  stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != '1))     flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (freeze && (freeze_cnt_q != '1))   freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It keeps a scoreboard of in-flight destination registers for EX, MEM and WB. From it, the block generates load-use stalls, branch-redirect flushes, global freeze on data-memory busy, and registered forwarding selects for the EX-stage operand muxes. It replaces ad-hoc bypass/stall equations in the datapath with one clocked control block.

## Interface
Parameters:
- REG_AW, 5, register address width (x0..x31)
- FWD_W, 2, forwarding-select width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1 / id_rs2  in  REG_AW  ID source addresses
- id_rs1_used / id_rs2_used  in  1  source actually read (Rs2 only for R/S/B types)
- id_rd  in  REG_AW  ID destination
- id_reg_wr  in  1  ID instruction writes rd
- id_mem_rd  in  1  ID instruction is a load
- ex_redirect  in  1  EX resolved a control transfer needing a PC redirect (branch/JAL)
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load ID/EX with a NOP (all enables 0)
- flush_ifid / flush_idex  out  1  squash IF/ID and ID/EX contents
- freeze  out  1  hold every pipeline register
- fwd_rs1_sel / fwd_rs2_sel  out  FWD_W  EX operand source: 0 regfile, 1 EX/MEM ALU result, 2 MEM/WB writeback value
- id_wb_bypass_rs1 / id_wb_bypass_rs2  out  1  ID read hits the register being written this cycle; use writeback value

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry is {valid, rd, reg_wr, mem_rd}.
  - When freeze=0, entries shift EX→MEM→WB each cycle and WB retires.
  - EX loads the ID fields, or an invalid entry when bubble_ex or flush_idex is set.
- An entry is a hazard source only if valid & reg_wr & rd≠0. rd=0 never matches.
- Load-use: if id_valid and a used rs equals the EX entry's rd while EX.mem_rd=1, assert stall_if, stall_id and bubble_ex for one cycle.
- Forwarding, computed when ID advances into EX and registered:
  - sel=1 if the rs matches the EX entry (non-load).
  - Else sel=2 if the rs matches the MEM entry (load or ALU).
  - Else 0.
  - The youngest match wins. An unused rs gives sel 0.
- WB bypass (combinational): id_wb_bypass_rsN=1 when rsN matches the WB entry.
- Controller FSM:
  - RUN: normal flow. Load-use goes to RUN via a one-cycle stall; no separate state is required. Redirect goes to FLUSH. mem_busy goes to FREEZE.
  - FLUSH: one cycle. flush_ifid=flush_idex=1, and the EX entry loaded is invalid. Then return to RUN.
  - FREEZE: freeze=stall_if=stall_id=1, and the scoreboard holds. On mem_busy deassertion, return to RUN. If ex_redirect is still high on leaving, go to FLUSH.
- Priority: freeze > redirect/flush > load-use stall. A load-use stall coinciding with a redirect is dropped, because the ID instruction is squashed.

## Timing
- Reset values:
  - All scoreboard valids 0; FSM in RUN.
  - All stall, flush, bubble and freeze outputs 0.
  - fwd selects 0; WB bypasses 0.
- stall_*, bubble_ex, flush_*, freeze and id_wb_bypass_* are combinational from the current inputs and state, with zero-cycle latency.
- fwd_rs*_sel are registered. They are valid during the EX cycle of the instruction they belong to, and hold during freeze.
- The load-use stall lasts exactly 1 cycle. The dependent instruction then forwards from MEM/WB (sel=2).
- A redirect costs 2 bubbles (IF/ID and ID/EX).
- rst_n assertion mid-stall or mid-freeze returns to the reset state immediately (asynchronous reset).

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds 32-bit saturating counters stall_cnt, flush_cnt and freeze_cnt, each incremented once per cycle its condition is active.
  - Adds output ports for the three counters; all are reset to 0.
- HAZARD_PERF_CNT_EN undefined: no counters and no counter ports.

## Structure
- riscv_pipe_pkg holds:
  - The FWD_* select constants (REGFILE=0, EXMEM=1, MEMWB=2).
  - The FSM state enum {RUN, FLUSH, FREEZE}.
  - The scoreboard entry struct.
- One sub-module, hazard_scoreboard, holds the 3-entry shift register and the match/compare logic. The top level holds the FSM, the priority logic and the counters.

## Test plan
- ADD x5 followed by SUB using x5 → next cycle fwd_rs1_sel=1; no stall.
- LD x6 followed immediately by ADD x7,x6,x1 → stall_if=stall_id=bubble_ex=1 for 1 cycle; ADD then sees fwd_rs1_sel=2.
- ADDI x0 followed by a use of x0 → no stall; fwd selects 0.
- ex_redirect pulse while ID holds a load-use dependent → flush_ifid=flush_idex=1 and no stall; the next EX entry is invalid.
- mem_busy held 3 cycles with a redirect pending → freeze=1 for 3 cycles and no flush; FLUSH occurs on the 4th cycle.
- rst_n low during FREEZE → all outputs 0 immediately and scoreboard cleared. With HAZARD_PERF_CNT_EN, freeze_cnt resets to 0.
